hub75_sink: RTL and testbench

Receive-side model of a HUB75 panel: oversamples the HUB75 pins (shift clock, latch, OE, row address, RGB) on the system clock and reconstructs what a physical panel would display. It deserializes each shifted line, captures it on latch, and measures OE-active and blanking durations per row. It sits in the verification and loopback path opposite the driver's timer and shifter, and checks bit-plane weighting and row sequencing in hardware.

---
 rtl/hub75_sink.sv | 174 +++++++++++++++++
 tb/tb_hub75_sink.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hub75_sink.sv
// Reconstructs a HUB75 panel's view of the bus: deserializes and latches lines, times OE-on / blanking per row.
// Latency: input edge sampled at clk k -> outputs at k+2; no backpressure, results are one-cycle pulses.
module hub75_sink #(
    parameter int vpixel_p   = 64,
    parameter int hpixel_p   = 64,
    parameter int segments_p = 2,
    parameter int cnt_wd_p   = 20
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  i_clr,
    input  logic                                  i_hub_clk,
    input  logic                                  i_hub_lat,
    input  logic                                  i_hub_oe_n,
    input  logic [$clog2(vpixel_p)-1:0]           i_hub_addr,
    input  logic [3*segments_p-1:0]               i_hub_rgb,
    output logic                                  o_line_valid,
    output logic [hpixel_p*3*segments_p-1:0]      o_line_data,
    output logic [$clog2(hpixel_p):0]             o_line_cols,
    output logic [$clog2(vpixel_p)-1:0]           o_line_row,
    output logic                                  o_on_valid,
    output logic [cnt_wd_p-1:0]                   o_on_cycles,
    output logic [$clog2(vpixel_p)-1:0]           o_on_row,
    output logic [cnt_wd_p-1:0]                   o_blank_cycles,
    output logic                                  o_err_cols,
    output logic                                  o_err_addr
);
    localparam int AW = $clog2(vpixel_p);
    localparam int PW = 3 * segments_p;
    localparam int LW = hpixel_p * PW;
    localparam int CW = $clog2(hpixel_p) + 1;
    localparam logic [2:0] CTL_RST = 3'b100;

    typedef enum logic {BLANK, ON} state_t;

    // Control bits are {oe_n, lat, hub_clk}; data rides the same two stages so it aligns with edges.
    logic [2:0]       ctl_s1_q, ctl_s2_q, ctl_s3_q;
    logic [AW+PW-1:0] dat_s1_q, dat_s2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctl_s1_q <= CTL_RST;
            ctl_s2_q <= CTL_RST;
            ctl_s3_q <= CTL_RST;
            dat_s1_q <= '0;
            dat_s2_q <= '0;
        end else begin
            ctl_s1_q <= {i_hub_oe_n, i_hub_lat, i_hub_clk};
            ctl_s2_q <= ctl_s1_q;
            ctl_s3_q <= ctl_s2_q;
            dat_s1_q <= {i_hub_addr, i_hub_rgb};
            dat_s2_q <= dat_s1_q;
        end
    end

    logic          hclk_rise, lat_rise, oe_fall, oe_rise;
    logic [AW-1:0] addr_s2;
    logic [PW-1:0] rgb_s2;

    assign hclk_rise = ctl_s2_q[0] & ~ctl_s3_q[0];
    assign lat_rise  = ctl_s2_q[1] & ~ctl_s3_q[1];
    assign oe_fall   = ~ctl_s2_q[2] & ctl_s3_q[2];
    assign oe_rise   = ctl_s2_q[2] & ~ctl_s3_q[2];
    assign addr_s2   = dat_s2_q[AW+PW-1:PW];
    assign rgb_s2    = dat_s2_q[PW-1:0];

    logic [LW-1:0] shift_q, shift_d, line_data_q, line_data_d;
    logic [CW-1:0] cols_q, cols_d, line_cols_q, line_cols_d;
    logic [AW-1:0] line_row_q, line_row_d;
    logic          line_valid_q, line_valid_d, err_cols_q, err_cols_d;

    always_comb begin
        shift_d      = shift_q;
        cols_d       = cols_q;
        line_data_d  = line_data_q;
        line_cols_d  = line_cols_q;
        line_row_d   = line_row_q;
        line_valid_d = 1'b0;
        err_cols_d   = err_cols_q & ~i_clr;
        if (hclk_rise) begin
            shift_d = {shift_q[LW-PW-1:0], rgb_s2};
            if (cols_q != CW'(hpixel_p + 1)) cols_d = cols_q + CW'(1);
        end
        // Latch sees the post-shift view so a coincident shift clock is included.
        if (lat_rise) begin
            line_valid_d = 1'b1;
            line_data_d  = shift_d;
            line_cols_d  = cols_d;
            line_row_d   = addr_s2;
            if (cols_d != CW'(hpixel_p)) err_cols_d = 1'b1;
            cols_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q      <= '0;
            cols_q       <= '0;
            line_data_q  <= '0;
            line_cols_q  <= '0;
            line_row_q   <= '0;
            line_valid_q <= 1'b0;
            err_cols_q   <= 1'b0;
        end else begin
            shift_q      <= shift_d;
            cols_q       <= cols_d;
            line_data_q  <= line_data_d;
            line_cols_q  <= line_cols_d;
            line_row_q   <= line_row_d;
            line_valid_q <= line_valid_d;
            err_cols_q   <= err_cols_d;
        end
    end

    state_t                state_q;
    logic [cnt_wd_p-1:0]   on_cnt_q, blank_cnt_q, on_cycles_q, blank_cycles_q;
    logic [AW-1:0]         cap_row_q, on_row_q;
    logic                  on_valid_q, err_addr_q;

    // Counters restart at 1 on a state change: the transition cycle belongs to the new period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= BLANK;
            on_cnt_q       <= '0;
            blank_cnt_q    <= '0;
            on_cycles_q    <= '0;
            blank_cycles_q <= '0;
            cap_row_q      <= '0;
            on_row_q       <= '0;
            on_valid_q     <= 1'b0;
            err_addr_q     <= 1'b0;
        end else begin
            on_valid_q <= 1'b0;
            err_addr_q <= err_addr_q & ~i_clr;
            case (state_q)
                BLANK: begin
                    if (oe_fall) begin
                        cap_row_q <= addr_s2;
                        on_cnt_q  <= cnt_wd_p'(1);
                        state_q   <= ON;
                    end else if (blank_cnt_q != {cnt_wd_p{1'b1}}) begin
                        blank_cnt_q <= blank_cnt_q + cnt_wd_p'(1);
                    end
                end
                ON: begin
                    if (addr_s2 != cap_row_q) err_addr_q <= 1'b1;
                    if (oe_rise) begin
                        on_cycles_q    <= on_cnt_q;
                        blank_cycles_q <= blank_cnt_q;
                        on_row_q       <= cap_row_q;
                        on_valid_q     <= 1'b1;
                        on_cnt_q       <= '0;
                        blank_cnt_q    <= cnt_wd_p'(1);
                        state_q        <= BLANK;
                    end else if (on_cnt_q != {cnt_wd_p{1'b1}}) begin
                        on_cnt_q <= on_cnt_q + cnt_wd_p'(1);
                    end
                end
                default: state_q <= BLANK;
            endcase
        end
    end

    assign o_line_valid   = line_valid_q;
    assign o_line_data    = line_data_q;
    assign o_line_cols    = line_cols_q;
    assign o_line_row     = line_row_q;
    assign o_on_valid     = on_valid_q;
    assign o_on_cycles    = on_cycles_q;
    assign o_on_row       = on_row_q;
    assign o_blank_cycles = blank_cycles_q;
    assign o_err_cols     = err_cols_q;
    assign o_err_addr     = err_addr_q;
endmodule

// File: tb/tb_hub75_sink.sv
// Bench for hub75_sink: pixel-history line model plus input-level OE duration scoreboard.
module tb_hub75_sink;
    localparam int HP = 64, VP = 64, SEG = 2, CNT = 20;
    localparam int PW = 3 * SEG, LW = HP * PW, CW = 7, AW = 6;

    logic           clk = 1'b0, rst_n = 1'b0, i_clr = 1'b0;
    logic           i_hub_clk = 1'b0, i_hub_lat = 1'b0, i_hub_oe_n = 1'b1;
    logic [AW-1:0]  i_hub_addr = '0;
    logic [PW-1:0]  i_hub_rgb = '0;
    logic           o_line_valid, o_on_valid, o_err_cols, o_err_addr;
    logic [LW-1:0]  o_line_data;
    logic [CW-1:0]  o_line_cols;
    logic [AW-1:0]  o_line_row, o_on_row;
    logic [CNT-1:0] o_on_cycles, o_blank_cycles;

    hub75_sink #(.vpixel_p(VP), .hpixel_p(HP), .segments_p(SEG), .cnt_wd_p(CNT)) dut (
        .clk(clk), .rst_n(rst_n), .i_clr(i_clr), .i_hub_clk(i_hub_clk), .i_hub_lat(i_hub_lat),
        .i_hub_oe_n(i_hub_oe_n), .i_hub_addr(i_hub_addr), .i_hub_rgb(i_hub_rgb),
        .o_line_valid(o_line_valid), .o_line_data(o_line_data), .o_line_cols(o_line_cols),
        .o_line_row(o_line_row), .o_on_valid(o_on_valid), .o_on_cycles(o_on_cycles),
        .o_on_row(o_on_row), .o_blank_cycles(o_blank_cycles), .o_err_cols(o_err_cols),
        .o_err_addr(o_err_addr));

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;

    task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Line model: every pixel shifted since reset; column c is the c-th most recent one.
    logic [PW-1:0] pix_q[$];

    function automatic logic [LW-1:0] exp_line();
        logic [LW-1:0] r = '0;
        for (int c = 0; c < HP; c++)
            if (c < pix_q.size()) r[c*PW +: PW] = pix_q[pix_q.size()-1-c];
        return r;
    endfunction

    // OE model: run lengths of the input level counted in clk cycles.
    int  hi_run = 0, lo_run = 0, periods = 0, on_pulses = 0;
    bit  prev_oe = 1'b1, first_blank = 1'b1, prev_on_valid = 1'b0;
    int  exp_on_q[$], exp_blank_q[$], exp_row_q[$];
    logic [CNT-1:0] last_on, last_blank;
    logic [AW-1:0]  last_row;

    always @(posedge clk) begin
        if (!rst_n) begin
            hi_run = 0; lo_run = 0; prev_oe = 1'b1; first_blank = 1'b1;
            exp_on_q.delete(); exp_blank_q.delete(); exp_row_q.delete();
        end else begin
            if (i_hub_oe_n) begin
                if (!prev_oe) begin exp_on_q.push_back(lo_run); hi_run = 0; end
                hi_run++;
            end else begin
                if (prev_oe) begin
                    exp_blank_q.push_back(first_blank ? -1 : hi_run);
                    first_blank = 1'b0;
                    lo_run = 0;
                end
                lo_run++;
            end
            prev_oe = i_hub_oe_n;
        end
    end

    always @(negedge clk) begin
        if (rst_n && o_on_valid) begin
            on_pulses++;
            last_on = o_on_cycles; last_blank = o_blank_cycles; last_row = o_on_row;
            if (prev_on_valid) check("on_valid_width", 1, 0);
            if (exp_on_q.size() == 0 || exp_blank_q.size() == 0 || exp_row_q.size() == 0) begin
                check("on_unexpected_pulse", 1, 0);
            end else begin
                int b;
                check("on_cycles", o_on_cycles, exp_on_q.pop_front());
                b = exp_blank_q.pop_front();
                if (b >= 0) check("blank_cycles", o_blank_cycles, b);
                check("on_row", o_on_row, exp_row_q.pop_front());
            end
        end
        prev_on_valid = o_on_valid;
    end

    task automatic shift_col(input logic [PW-1:0] v);
        @(negedge clk) i_hub_rgb = v;
        @(negedge clk) i_hub_clk = 1'b1;
        repeat (2) @(negedge clk);
        i_hub_clk = 1'b0;
        pix_q.push_back(v);
        if (pix_q.size() > HP) void'(pix_q.pop_front());
    endtask

    logic [LW-1:0] cap_data;

    task automatic do_latch(input logic [AW-1:0] row, input bit with_clk, input logic [PW-1:0] v,
                            input int exp_cols, input bit exp_err, input string tag);
        bit got = 1'b0;
        if (with_clk) @(negedge clk) i_hub_rgb = v;
        @(negedge clk);
        i_hub_addr = row;
        i_hub_lat  = 1'b1;
        if (with_clk) i_hub_clk = 1'b1;
        repeat (2) @(negedge clk);
        i_hub_lat = 1'b0;
        i_hub_clk = 1'b0;
        if (with_clk) begin
            pix_q.push_back(v);
            if (pix_q.size() > HP) void'(pix_q.pop_front());
        end
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (o_line_valid) got = 1'b1;
        end
        check({tag, "_valid"}, got, 1);
        if (got) begin
            cap_data = o_line_data;
            check({tag, "_data"}, o_line_data, exp_line());
            check({tag, "_cols"}, o_line_cols, exp_cols);
            check({tag, "_row"}, o_line_row, row);
            check({tag, "_err"}, o_err_cols, exp_err);
            @(negedge clk) check({tag, "_width"}, o_line_valid, 0);
        end
    endtask

    task automatic pulse_clr();
        @(negedge clk) i_clr = 1'b1;
        @(negedge clk) i_clr = 1'b0;
    endtask

    // Drives OE high for 'hi' cycles (counting from the previous rise) then low for 'lo' cycles.
    task automatic oe_period(input int hi, input int lo, input logic [AW-1:0] row);
        repeat (hi - 1) @(negedge clk);
        @(negedge clk);
        i_hub_addr = row;
        i_hub_oe_n = 1'b0;
        exp_row_q.push_back(row);
        periods++;
        repeat (lo) @(negedge clk);
        i_hub_oe_n = 1'b1;
    endtask

    task automatic wait_on_pulses(input string tag);
        for (int i = 0; i < 20 && on_pulses != periods; i++) @(negedge clk);
        check(tag, on_pulses, periods);
    endtask

    typedef struct {
        int            ncols;
        bit            clr;
        logic [AW-1:0] row;
        int            exp_cols;
        bit            exp_err;
    } line_vec_t;

    line_vec_t tbl[7];

    initial begin
        bit err_m;
        tbl[0] = '{64, 1'b0, 6'd5,  64, 1'b0};
        tbl[1] = '{63, 1'b0, 6'd7,  63, 1'b1};
        tbl[2] = '{64, 1'b1, 6'd1,  64, 1'b0};
        tbl[3] = '{66, 1'b0, 6'd2,  65, 1'b1};
        tbl[4] = '{0,  1'b1, 6'd9,  0,  1'b1};
        tbl[5] = '{65, 1'b1, 6'd62, 65, 1'b1};
        tbl[6] = '{64, 1'b1, 6'd63, 64, 1'b0};

        repeat (3) @(negedge clk);
        check("rst_line_data", o_line_data, 0);
        check("rst_ctrl", {o_line_valid, o_line_cols, o_line_row, o_on_valid, o_on_cycles,
                           o_on_row, o_blank_cycles, o_err_cols, o_err_addr}, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            if (tbl[i].clr) begin
                pulse_clr();
                check($sformatf("tbl%0d_clr", i), o_err_cols, 0);
            end
            for (int c = 0; c < tbl[i].ncols; c++) shift_col(PW'(c + 7 * i));
            do_latch(tbl[i].row, 1'b0, '0, tbl[i].exp_cols, tbl[i].exp_err, $sformatf("tbl%0d", i));
            if (i == 0) begin
                check("tbl0_col63", cap_data[63*PW +: PW], 6'h00);
                check("tbl0_col0", cap_data[0 +: PW], 6'h3F);
            end
        end

        // Shift clock and latch rising together on the 64th column.
        for (int c = 0; c < 63; c++) shift_col(PW'($urandom));
        do_latch(6'd11, 1'b1, 6'h2A, 64, 1'b0, "coincident");
        check("coincident_col0", cap_data[0 +: PW], 6'h2A);

        oe_period(30, 100, 6'd8);
        oe_period(40, 200, 6'd3);
        wait_on_pulses("oe_pair_pulses");
        check("oe_pair_on", last_on, 200);
        check("oe_pair_blank", last_blank, 40);
        check("oe_pair_row", last_row, 3);

        // Address moves mid-period: flag two cycles later, clear loses to a live error.
        repeat (10) @(negedge clk);
        i_hub_addr = 6'd3;
        i_hub_oe_n = 1'b0;
        exp_row_q.push_back(6'd3);
        periods++;
        repeat (10) @(negedge clk);
        i_hub_addr = 6'd4;
        repeat (2) @(negedge clk);
        check("err_addr_early", o_err_addr, 0);
        @(negedge clk) check("err_addr_set", o_err_addr, 1);
        pulse_clr();
        check("err_addr_clr_vs_err", o_err_addr, 1);
        i_hub_oe_n = 1'b1;
        wait_on_pulses("err_addr_pulses");
        check("err_addr_row", last_row, 3);
        repeat (5) @(negedge clk);
        pulse_clr();
        check("err_addr_cleared", o_err_addr, 0);
        i_hub_addr = 6'd9;
        repeat (4) @(negedge clk);
        check("err_addr_blank_move", o_err_addr, 0);

        for (int i = 0; i < 8; i++)
            oe_period($urandom_range(3, 60), $urandom_range(3, 120), AW'($urandom));
        wait_on_pulses("rand_oe_pulses");
        check("rand_oe_err_addr", o_err_addr, 0);

        pulse_clr();
        err_m = 1'b0;
        for (int i = 0; i < 5; i++) begin
            int n = $urandom_range(62, 66);
            int ec = (n > HP + 1) ? HP + 1 : n;
            for (int c = 0; c < n; c++) shift_col(PW'($urandom));
            if (ec != HP) err_m = 1'b1;
            do_latch(AW'($urandom), 1'b0, '0, ec, err_m, $sformatf("rand%0d", i));
        end

        // Reset mid-line after leaving the error flag set.
        for (int c = 0; c < 63; c++) shift_col(PW'($urandom));
        do_latch(6'd20, 1'b0, '0, 63, 1'b1, "pre_rst");
        for (int c = 0; c < 30; c++) shift_col(PW'($urandom));
        @(negedge clk) rst_n = 1'b0;
        #1;
        check("midrst_line_data", o_line_data, 0);
        check("midrst_ctrl", {o_line_valid, o_line_cols, o_line_row, o_on_valid, o_on_cycles,
                              o_on_row, o_blank_cycles, o_err_cols, o_err_addr}, 0);
        pix_q.delete();
        @(negedge clk) rst_n = 1'b1;
        for (int c = 0; c < 20; c++) shift_col(PW'($urandom));
        do_latch(6'd33, 1'b0, '0, 20, 1'b1, "post_rst");

        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
